trigger_charge_extractor: RTL and testbench

// Downstream consumer of the IIR/moving-mean CFD self-trigger stage. Takes its filtered

---
 rtl/trigger_charge_extractor.sv | 148 ++++++++++++++
 tb/tb_trigger_charge_extractor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/trigger_charge_extractor.sv
// Per-trigger charge integrator for the CFD self-trigger stage. Each accepted trigger produces
// one record with the window sum, the minimum and its position, a timestamp and a pileup flag.
module trigger_charge_extractor #(
    parameter int unsigned INT_LEN = 64,
    parameter int unsigned HOLDOFF = 32,
    parameter int unsigned TS_W    = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic signed [15:0] x,
    input  logic               trigger_in,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [TS_W-1:0]    evt_ts,
    output logic signed [23:0] evt_charge,
    output logic signed [15:0] evt_peak,
    output logic [7:0]         evt_peak_pos,
    output logic               evt_pileup,
    output logic [15:0]        drop_count
);

    localparam int unsigned HoldW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [8:0]       IdxLast  = 9'(INT_LEN - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {StIdle, StInteg, StDone, StHoldoff} state_e;

    state_e             state_q, state_d;
    logic [TS_W-1:0]    ts_q;
    logic [TS_W-1:0]    ts_lat_q, ts_lat_d;
    logic               trig_q;
    logic signed [23:0] acc_q, acc_d;
    logic signed [15:0] peak_q, peak_d;
    logic [7:0]         pos_q, pos_d;
    logic               pileup_q, pileup_d;
    logic [8:0]         idx_q, idx_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic               rise;
    logic               load;
    logic               drop_inc;
    logic signed [23:0] x_ext;

    assign rise  = enable & trigger_in & ~trig_q;
    assign x_ext = {{8{x[15]}}, x};

    always_comb begin
        state_d  = state_q;
        ts_lat_d = ts_lat_q;
        acc_d    = acc_q;
        peak_d   = peak_q;
        pos_d    = pos_q;
        pileup_d = pileup_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        load     = 1'b0;
        drop_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    // A pending record blocks a new window; the trigger is lost.
                    if (evt_valid) begin
                        drop_inc = 1'b1;
                    end else begin
                        ts_lat_d = ts_q;
                        acc_d    = x_ext;
                        peak_d   = x;
                        pos_d    = 8'd0;
                        pileup_d = 1'b0;
                        idx_d    = 9'd1;
                        state_d  = (INT_LEN == 1) ? StDone : StInteg;
                    end
                end
            end
            StInteg: begin
                if (enable) begin
                    acc_d = acc_q + x_ext;
                    if (x < peak_q) begin
                        peak_d = x;
                        pos_d  = idx_q[7:0];
                    end
                    if (rise) pileup_d = 1'b1;
                    idx_d = idx_q + 9'd1;
                    if (idx_q == IdxLast) state_d = StDone;
                end
            end
            StDone: begin
                load     = 1'b1;
                drop_inc = rise;
                hold_d   = '0;
                state_d  = (HOLDOFF > 0) ? StHoldoff : StIdle;
            end
            StHoldoff: begin
                if (enable) begin
                    drop_inc = rise;
                    if (hold_q == HoldLast) state_d = StIdle;
                    else                    hold_d  = hold_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            ts_q         <= '0;
            ts_lat_q     <= '0;
            trig_q       <= 1'b0;
            acc_q        <= '0;
            peak_q       <= '0;
            pos_q        <= '0;
            pileup_q     <= 1'b0;
            idx_q        <= '0;
            hold_q       <= '0;
            evt_valid    <= 1'b0;
            evt_ts       <= '0;
            evt_charge   <= '0;
            evt_peak     <= '0;
            evt_peak_pos <= '0;
            evt_pileup   <= 1'b0;
            drop_count   <= '0;
        end else begin
            ts_q     <= ts_q + 1'b1;
            state_q  <= state_d;
            ts_lat_q <= ts_lat_d;
            acc_q    <= acc_d;
            peak_q   <= peak_d;
            pos_q    <= pos_d;
            pileup_q <= pileup_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            if (enable) trig_q <= trigger_in;
            if (evt_valid && evt_ready) evt_valid <= 1'b0;
            // DONE is only reachable with evt_valid low, so a load never collides with a record.
            if (load) begin
                evt_valid    <= 1'b1;
                evt_ts       <= ts_lat_q;
                evt_charge   <= acc_q;
                evt_peak     <= peak_q;
                evt_peak_pos <= pos_q;
                evt_pileup   <= pileup_q;
            end
            if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_trigger_charge_extractor.sv
// Directed bench: a short-window instance for the handshake/drop paths and a 256-sample
// instance for enable gating, mid-window reset and full-scale accumulation.
module tb_trigger_charge_extractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic               en_a, trig_a, rdy_a;
    logic signed [15:0] x_a;
    logic               va, pu_a;
    logic [31:0]        ts_a;
    logic signed [23:0] ch_a;
    logic signed [15:0] pk_a;
    logic [7:0]         pos_a;
    logic [15:0]        dc_a;

    logic               en_b, trig_b, rdy_b;
    logic signed [15:0] x_b;
    logic               vb, pu_b;
    logic [31:0]        ts_b;
    logic signed [23:0] ch_b;
    logic signed [15:0] pk_b;
    logic [7:0]         pos_b;
    logic [15:0]        dc_b;

    trigger_charge_extractor #(.INT_LEN(4), .HOLDOFF(2), .TS_W(32)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(en_a), .x(x_a), .trigger_in(trig_a),
        .evt_valid(va), .evt_ready(rdy_a), .evt_ts(ts_a), .evt_charge(ch_a),
        .evt_peak(pk_a), .evt_peak_pos(pos_a), .evt_pileup(pu_a), .drop_count(dc_a)
    );

    trigger_charge_extractor #(.INT_LEN(256), .HOLDOFF(0), .TS_W(32)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(en_b), .x(x_b), .trigger_in(trig_b),
        .evt_valid(vb), .evt_ready(rdy_b), .evt_ts(ts_b), .evt_charge(ch_b),
        .evt_peak(pk_b), .evt_peak_pos(pos_b), .evt_pileup(pu_b), .drop_count(dc_b)
    );

    // Reference free-running timestamp: counts every clock since reset release.
    logic [31:0] cyc;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= '0;
        else          cyc <= cyc + 32'd1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ts_exp;
    int sum;
    int v;

    initial begin
        reset_n = 1'b0;
        en_a = 0; trig_a = 0; rdy_a = 0; x_a = '0;
        en_b = 0; trig_b = 0; rdy_b = 0; x_b = '0;
        repeat (2) step();
        check_eq("rst_valid", 32'(va), 0);
        check_eq("rst_charge", 32'(ch_a), 0);
        check_eq("rst_drop", 32'(dc_a), 0);
        reset_n = 1'b1;
        step();

        // T1/T2: basic window, trigger held high for 10 samples.
        en_a = 1;
        ts_exp = cyc;
        trig_a = 1; x_a = -100; step();
        x_a = -300; step();
        x_a = -300; step();
        x_a = -50;  step();
        check_eq("t1_latency", 32'(va), 0);
        x_a = 7; step();
        check_eq("t1_valid", 32'(va), 1);
        check_eq("t1_charge", 32'(ch_a), -750);
        check_eq("t1_peak", 32'(pk_a), -300);
        check_eq("t1_pos", 32'(pos_a), 1);
        check_eq("t1_pileup", 32'(pu_a), 0);
        check_eq("t1_ts", ts_a, ts_exp);
        repeat (5) step();
        trig_a = 0; step();
        check_eq("t2_hold_valid", 32'(va), 1);
        rdy_a = 1; step();
        check_eq("t2_accept", 32'(va), 0);
        rdy_a = 0;
        repeat (3) step();
        check_eq("t2_single_event", 32'(va), 0);
        check_eq("t2_drop", 32'(dc_a), 0);

        // T3: back-pressure, three trigger pulses while the record is pending.
        ts_exp = cyc;
        trig_a = 1; x_a = 10; step();
        trig_a = 0; x_a = 20; step();
        x_a = -5; step();
        x_a = -5; step();
        x_a = 0;  step();
        check_eq("t3_valid", 32'(va), 1);
        check_eq("t3_charge", 32'(ch_a), 20);
        check_eq("t3_pos", 32'(pos_a), 2);
        for (int i = 0; i < 3; i++) begin
            trig_a = 1; step();
            trig_a = 0; step();
        end
        check_eq("t3_drop", 32'(dc_a), 3);
        check_eq("t3_stable_charge", 32'(ch_a), 20);
        check_eq("t3_stable_peak", 32'(pk_a), -5);
        check_eq("t3_stable_ts", ts_a, ts_exp);
        rdy_a = 1; step();
        check_eq("t3_accept", 32'(va), 0);
        rdy_a = 0;

        // T4: second edge at window index 2, then an edge in holdoff.
        x_a = 1;
        trig_a = 1; step();
        trig_a = 0; step();
        trig_a = 1; step();
        trig_a = 0; step();
        step();
        check_eq("t4_valid", 32'(va), 1);
        check_eq("t4_pileup", 32'(pu_a), 1);
        check_eq("t4_charge", 32'(ch_a), 4);
        check_eq("t4_tie_pos", 32'(pos_a), 0);
        check_eq("t4_drop_unchanged", 32'(dc_a), 3);
        trig_a = 1; step();
        trig_a = 0; step();
        check_eq("t4_holdoff_drop", 32'(dc_a), 4);
        step();
        // Accept and rise on the same clock in IDLE: trigger is dropped.
        rdy_a = 1; trig_a = 1; step();
        check_eq("t4_same_clk_accept", 32'(va), 0);
        check_eq("t4_same_clk_drop", 32'(dc_a), 5);
        rdy_a = 0; trig_a = 0;
        repeat (6) step();
        check_eq("t4_no_event", 32'(va), 0);
        en_a = 0;

        // T5: enable toggles every clock; disabled-cycle samples must not count.
        sum = 0;
        ts_exp = cyc;
        for (int i = 0; i < 256; i++) begin
            v = (i == 100 || i == 200) ? -1000 : ((i * 37) % 200) - 150;
            sum += v;
            en_b = 1; trig_b = 1; x_b = 16'(v); step();
            en_b = 0; x_b = 16'sd30000; step();
        end
        check_eq("t5_valid", 32'(vb), 1);
        check_eq("t5_charge", 32'(ch_b), sum);
        check_eq("t5_peak", 32'(pk_b), -1000);
        check_eq("t5_pos", 32'(pos_b), 100);
        check_eq("t5_pileup", 32'(pu_b), 0);
        check_eq("t5_ts", ts_b, ts_exp);
        trig_b = 0; rdy_b = 1; step();
        check_eq("t5_accept", 32'(vb), 0);
        rdy_b = 0;

        // T6: reset at window index 30, then a full-scale window.
        en_b = 1; x_b = -1; trig_b = 1;
        repeat (30) step();
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(vb), 0);
        check_eq("t6_rst_charge", 32'(ch_b), 0);
        check_eq("t6_rst_drop_a", 32'(dc_a), 0);
        check_eq("t6_rst_ts", ts_b, 0);
        step();
        trig_b = 0; reset_n = 1'b1;
        repeat (2) step();
        ts_exp = cyc;
        trig_b = 1; x_b = -16'sd32768;
        repeat (256) step();
        check_eq("t6_latency", 32'(vb), 0);
        step();
        check_eq("t6_valid", 32'(vb), 1);
        check_eq("t6_charge", 32'(ch_b), -8388608);
        check_eq("t6_peak", 32'(pk_b), -32768);
        check_eq("t6_pos", 32'(pos_b), 0);
        check_eq("t6_ts", ts_b, ts_exp);
        check_eq("t6_drop_b", 32'(dc_b), 0);
        rdy_b = 1; step();
        check_eq("t6_accept", 32'(vb), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
